// File: rtl/pwm_multi_phase.sv
// pwm_multi_phase
//   Multi-channel PWM / pulse-position generator. A single frame counter is
//   shared by all channels; each channel has its own duty, start delay and
//   output inversion. New settings are captured into staging registers on a
//   load strobe and only become active at a frame boundary, or immediately
//   while the generator is idle, so a running frame never sees a half update.
// Ports
//   clk         in   1                rising-edge clock
//   rst         in   1                asynchronous active-high reset
//   en          in   1                run enable (low: counter at 0, outputs idle)
//   load        in   1                capture period/duty/delay/inv into staging
//   period      in   WIDTH            frame length in clk cycles
//   duty        in   CHANNELS*WIDTH   per-channel high time
//   delay       in   CHANNELS*WIDTH   per-channel pulse start offset
//   inv         in   CHANNELS         per-channel output inversion
//   q           out  CHANNELS         registered channel outputs
//   frame_start out  1                pulse the cycle after the counter was 0
//   upd_done    out  1                pulse when staged settings became active
module pwm_multi_phase #(
  parameter int WIDTH    = 26,
  parameter int CHANNELS = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      load,
  input  logic [WIDTH-1:0]          period,
  input  logic [CHANNELS*WIDTH-1:0] duty,
  input  logic [CHANNELS*WIDTH-1:0] delay,
  input  logic [CHANNELS-1:0]       inv,
  output logic [CHANNELS-1:0]       q,
  output logic                      frame_start,
  output logic                      upd_done
);

  logic [WIDTH-1:0]          cnt_r;
  logic [WIDTH-1:0]          act_period_r;
  logic [WIDTH-1:0]          stg_period_r;
  logic [CHANNELS*WIDTH-1:0] act_duty_r;
  logic [CHANNELS*WIDTH-1:0] act_delay_r;
  logic [CHANNELS*WIDTH-1:0] stg_duty_r;
  logic [CHANNELS*WIDTH-1:0] stg_delay_r;
  logic [CHANNELS-1:0]       act_inv_r;
  logic [CHANNELS-1:0]       stg_inv_r;
  logic                      pending_r;

  logic                      run_s;
  logic                      wrap_s;
  logic                      apply_s;
  logic [WIDTH-1:0]          cnt_next_s;
  logic [CHANNELS-1:0]       q_next_s;

  // Run/wrap/apply decode; an idle generator (en low or period < 2) applies at once
  always_comb begin
    run_s   = en && (act_period_r >= WIDTH'(2));
    wrap_s  = run_s && (cnt_r == (act_period_r - WIDTH'(1)));
    apply_s = pending_r && (wrap_s || !run_s);
    if (!run_s) begin
      cnt_next_s = WIDTH'(0);
    end else if (wrap_s) begin
      cnt_next_s = WIDTH'(0);
    end else begin
      cnt_next_s = cnt_r + WIDTH'(1);
    end
  end

  // Per-channel level from the frame position relative to the channel's delay
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [WIDTH-1:0] duty_s;
    logic [WIDTH:0]   per_s;
    logic [WIDTH:0]   dly_s;
    logic [WIDTH:0]   d_s;
    logic [WIDTH:0]   p_s;
    logic             raw_s;

    // Clamp delay into the frame, then fold the position so pulses can straddle the wrap
    always_comb begin
      duty_s = act_duty_r[i*WIDTH +: WIDTH];
      per_s  = {1'b0, act_period_r};
      dly_s  = {1'b0, act_delay_r[i*WIDTH +: WIDTH]};
      if (dly_s > (per_s - (WIDTH+1)'(1))) begin
        d_s = per_s - (WIDTH+1)'(1);
      end else begin
        d_s = dly_s;
      end
      if ({1'b0, cnt_r} >= d_s) begin
        p_s = {1'b0, cnt_r} - d_s;
      end else begin
        p_s = {1'b0, cnt_r} + per_s - d_s;
      end
      if (duty_s >= act_period_r) begin
        raw_s = 1'b1;
      end else if (p_s < {1'b0, duty_s}) begin
        raw_s = 1'b1;
      end else begin
        raw_s = 1'b0;
      end
    end

    // Idle outputs are forced low, never inverted
    assign q_next_s[i] = run_s ? (raw_s ^ act_inv_r[i]) : 1'b0;
  end

  // Shared frame counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= WIDTH'(0);
    end else begin
      cnt_r <= cnt_next_s;
    end
  end

  // Staging capture and frame-synchronous transfer into the active set
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stg_period_r <= WIDTH'(0);
      stg_duty_r   <= (CHANNELS*WIDTH)'(0);
      stg_delay_r  <= (CHANNELS*WIDTH)'(0);
      stg_inv_r    <= CHANNELS'(0);
      act_period_r <= WIDTH'(0);
      act_duty_r   <= (CHANNELS*WIDTH)'(0);
      act_delay_r  <= (CHANNELS*WIDTH)'(0);
      act_inv_r    <= CHANNELS'(0);
      pending_r    <= 1'b0;
    end else begin
      if (apply_s) begin
        act_period_r <= stg_period_r;
        act_duty_r   <= stg_duty_r;
        act_delay_r  <= stg_delay_r;
        act_inv_r    <= stg_inv_r;
      end
      // A load on the apply edge keeps pending so the fresh values go out next boundary
      if (load) begin
        stg_period_r <= period;
        stg_duty_r   <= duty;
        stg_delay_r  <= delay;
        stg_inv_r    <= inv;
        pending_r    <= 1'b1;
      end else if (apply_s) begin
        pending_r    <= 1'b0;
      end
    end
  end

  // Registered outputs: each reflects the counter value of the previous cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q           <= CHANNELS'(0);
      frame_start <= 1'b0;
      upd_done    <= 1'b0;
    end else begin
      q           <= q_next_s;
      frame_start <= run_s && (cnt_r == WIDTH'(0));
      upd_done    <= apply_s;
    end
  end

endmodule

// File: tb/tb_pwm_multi_phase.sv
module tb_pwm_multi_phase;
  localparam int W = 26;
  localparam int C = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           en;
  logic           load;
  logic [W-1:0]   period;
  logic [C*W-1:0] duty;
  logic [C*W-1:0] delay;
  logic [C-1:0]   inv;
  logic [C-1:0]   q;
  logic           frame_start;
  logic           upd_done;

  pwm_multi_phase #(.WIDTH(W), .CHANNELS(C)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .period(period),
    .duty(duty), .delay(delay), .inv(inv), .q(q),
    .frame_start(frame_start), .upd_done(upd_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: frame position, active / staged settings, pending flag
  int m_cnt;
  int a_per, s_per;
  int a_duty[C], a_dly[C], s_duty[C], s_dly[C];
  bit a_inv[C], s_inv[C];
  bit m_pend;

  task automatic model_reset();
    m_cnt = 0; a_per = 0; s_per = 0; m_pend = 0;
    for (int c = 0; c < C; c++) begin
      a_duty[c] = 0; a_dly[c] = 0; a_inv[c] = 0;
      s_duty[c] = 0; s_dly[c] = 0; s_inv[c] = 0;
    end
  endtask

  // Channel is high when the distance from its (clamped) start, modulo the frame, is below duty
  function automatic bit level(int ch);
    int d;
    if (a_duty[ch] == 0) return 1'b0;
    if (a_duty[ch] >= a_per) return 1'b1;
    d = (a_dly[ch] < a_per - 1) ? a_dly[ch] : a_per - 1;
    return ((m_cnt - d + a_per) % a_per) < a_duty[ch];
  endfunction

  function automatic bit model_run();
    return en && (a_per >= 2);
  endfunction

  function automatic bit model_apply();
    return m_pend && (!model_run() || m_cnt == a_per - 1);
  endfunction

  // Advance one clock: predict, update model, clock the DUT, compare
  task automatic step();
    logic [C-1:0] eq;
    bit run, efs, app;
    run = model_run();
    for (int c = 0; c < C; c++) eq[c] = run ? (level(c) ^ a_inv[c]) : 1'b0;
    efs = run && (m_cnt == 0);
    app = model_apply();
    m_cnt = !run ? 0 : ((m_cnt == a_per - 1) ? 0 : m_cnt + 1);
    if (app) begin
      a_per = s_per;
      for (int c = 0; c < C; c++) begin
        a_duty[c] = s_duty[c]; a_dly[c] = s_dly[c]; a_inv[c] = s_inv[c];
      end
    end
    if (load) begin
      s_per = int'(period);
      for (int c = 0; c < C; c++) begin
        s_duty[c] = int'(duty[c*W +: W]);
        s_dly[c]  = int'(delay[c*W +: W]);
        s_inv[c]  = inv[c];
      end
      m_pend = 1'b1;
    end else if (app) begin
      m_pend = 1'b0;
    end
    @(posedge clk); #1;
    n_cmp++;
    if (q !== eq) begin
      n_bad++; $display("FAIL q: got %b expected %b (t=%0t)", q, eq, $time);
    end
    n_cmp++;
    if (frame_start !== efs) begin
      n_bad++; $display("FAIL frame_start: got %b expected %b (t=%0t)", frame_start, efs, $time);
    end
    n_cmp++;
    if (upd_done !== app) begin
      n_bad++; $display("FAIL upd_done: got %b expected %b (t=%0t)", upd_done, app, $time);
    end
  endtask

  task automatic set_cfg(int per, int d0, int d1, int l0, int l1, bit i0, bit i1);
    period = W'(per);
    duty   = {W'(d1), W'(d0)};
    delay  = {W'(l1), W'(l0)};
    inv    = {i1, i0};
  endtask

  task automatic load_once();
    load = 1'b1; step(); load = 1'b0;
  endtask

  // Step until the model counter reaches k; an expired budget is a failure
  task automatic run_to(int k);
    int n = 0;
    while (m_cnt != k && n < 200) begin step(); n++; end
    n_cmp++;
    if (m_cnt != k) begin n_bad++; $display("FAIL run_to: counter %0d never reached %0d", m_cnt, k); end
  endtask

  // Count highs over a window of steps
  task automatic window(int len, output int h0, output int h1, output int fs, output int up);
    h0 = 0; h1 = 0; fs = 0; up = 0;
    for (int i = 0; i < len; i++) begin
      step();
      h0 += int'(q[0]); h1 += int'(q[1]); fs += int'(frame_start); up += int'(upd_done);
    end
  endtask

  task automatic expect_eq(string name, int got, int exp);
    n_cmp++;
    if (got != exp) begin n_bad++; $display("FAIL %s: got %0d expected %0d", name, got, exp); end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; load = 1'b0; set_cfg(0, 0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({q, frame_start, upd_done} !== 4'b0000) begin
      n_bad++; $display("FAIL reset: got %b expected 0000", {q, frame_start, upd_done});
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    int h0, h1, fs, up;
    set_cfg(10, 3, 4, 0, 8, 0, 0);
    en = 1'b1;
    load_once();
    repeat (3) step();
    window(30, h0, h1, fs, up);
    expect_eq("basic_q0_highs", h0, 9);
    expect_eq("basic_q1_highs", h1, 12);
    expect_eq("basic_frame_starts", fs, 3);
  endtask

  task automatic test_extremes();
    int h0, h1, fs, up;
    set_cfg(10, 0, 10, 0, 0, 0, 0); load_once();
    repeat (12) step();
    window(10, h0, h1, fs, up);
    expect_eq("duty0_highs", h0, 0);
    expect_eq("duty_eq_period_highs", h1, 10);
    set_cfg(10, 0, 15, 3, 3, 1, 1); load_once();
    repeat (12) step();
    window(10, h0, h1, fs, up);
    expect_eq("duty0_inv_highs", h0, 10);
    expect_eq("duty_gt_period_inv_highs", h1, 0);
  endtask

  task automatic test_midframe_load();
    int h0, h1, fs, up;
    set_cfg(10, 3, 4, 0, 8, 0, 0); load_once();
    repeat (12) step();
    run_to(4);
    set_cfg(10, 7, 4, 0, 8, 0, 0); load_once();
    window(15, h0, h1, fs, up);
    expect_eq("midframe_upd_pulses", up, 1);
    window(10, h0, h1, fs, up);
    expect_eq("midframe_new_duty_highs", h0, 7);
  endtask

  task automatic test_double_load();
    int h0, h1, fs, up;
    run_to(2);
    set_cfg(10, 5, 2, 0, 0, 0, 0); load_once();
    run_to(5);
    set_cfg(10, 6, 1, 0, 0, 0, 0); load_once();
    window(10, h0, h1, fs, up);
    expect_eq("double_load_upd_pulses", up, 1);
    window(10, h0, h1, fs, up);
    expect_eq("double_load_q0_highs", h0, 6);
    expect_eq("double_load_q1_highs", h1, 1);
  endtask

  task automatic test_rst_mid();
    int h0, h1, fs, up;
    set_cfg(10, 7, 7, 0, 0, 0, 0); load_once();
    repeat (12) step();
    run_to(6);
    expect_eq("pre_rst_q0_high", int'(q[0]), 1);
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({q, frame_start, upd_done} !== 4'b0000) begin
      n_bad++; $display("FAIL async_reset: got %b expected 0000", {q, frame_start, upd_done});
    end
    model_reset();
    @(posedge clk); #2 rst = 1'b0;
    window(15, h0, h1, fs, up);
    expect_eq("post_rst_q_highs", h0 + h1, 0);
    expect_eq("post_rst_frame_starts", fs, 0);
  endtask

  task automatic test_en_gap();
    int h0, h1, fs, up;
    set_cfg(10, 3, 4, 0, 8, 0, 1); load_once();
    repeat (15) step();
    run_to(5);
    en = 1'b0;
    window(20, h0, h1, fs, up);
    expect_eq("en_low_q_highs", h0 + h1, 0);
    en = 1'b1;
    step();
    expect_eq("en_rise_frame_start", int'(frame_start), 1);
    repeat (25) step();
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(29, 0) == 0) en = ~en;
      if ($urandom_range(7, 0) == 0 && !model_apply()) begin
        set_cfg($urandom_range(20, 0), $urandom_range(24, 0), $urandom_range(24, 0),
                $urandom_range(24, 0), $urandom_range(24, 0), 1'($urandom), 1'($urandom));
        load = 1'b1;
      end
      step();
      load = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_midframe_load();
    test_double_load();
    test_rst_mid();
    test_en_gap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
